// File: rtl/char_ram_writer_if.sv
// Byte-stream input and character-RAM write port of char_ram_writer.
// The master side feeds bytes and observes the RAM writes; the writer is the slave.
interface char_ram_writer_if #(
  parameter int ADDR_W = 11
);
  logic [7:0]        in_char;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] write_character_pos;
  logic [7:0]        write_character;
  logic              write_strobe;
  logic [ADDR_W-1:0] cursor_pos;
  logic              busy;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready,
    input  write_character_pos,
    input  write_character,
    input  write_strobe,
    input  cursor_pos,
    input  busy
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready,
    output write_character_pos,
    output write_character,
    output write_strobe,
    output cursor_pos,
    output busy
  );
endinterface

// File: rtl/char_ram_writer.sv
// Write-side client of the character RAM: turns a byte stream into cell writes,
// tracks a text cursor, clears the screen after reset and on form feed.
module char_ram_writer #(
  parameter int         COLS       = 40,
  parameter int         ROWS       = 15,
  parameter int         ADDR_W     = 11,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic             CLK,
  input  logic             n_reset,
  char_ram_writer_if.slave bus
);

  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0]  COL_ONE   = COL_W'(1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t            state,     state_nx;
  logic [ADDR_W-1:0] clear_pos, clear_pos_nx;
  logic [ADDR_W-1:0] cursor,    cursor_nx;
  logic [COL_W-1:0]  col,       col_nx;
  logic [ROW_W-1:0]  row,       row_nx;
  logic [ADDR_W-1:0] wr_pos,    wr_pos_nx;
  logic [7:0]        wr_char,   wr_char_nx;
  logic              wr_stb,    wr_stb_nx;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values computed by the combinational block before this edge.
  always_ff @(posedge CLK or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_CLEAR;
      clear_pos <= '0;
      cursor    <= '0;
      col       <= '0;
      row       <= '0;
      wr_pos    <= '0;
      wr_char   <= '0;
      wr_stb    <= 1'b0;
    end else begin
      state     <= state_nx;
      clear_pos <= clear_pos_nx;
      cursor    <= cursor_nx;
      col       <= col_nx;
      row       <= row_nx;
      wr_pos    <= wr_pos_nx;
      wr_char   <= wr_char_nx;
      wr_stb    <= wr_stb_nx;
    end
  end

  // NOTE: every signal written here is given a default first, so no path through
  // the case statements can leave a value unassigned and infer a latch.
  always_comb begin
    state_nx     = state;
    clear_pos_nx = clear_pos;
    cursor_nx    = cursor;
    col_nx       = col;
    row_nx       = row;
    wr_pos_nx    = wr_pos;
    wr_char_nx   = wr_char;
    wr_stb_nx    = 1'b0;

    unique case (state)
      ST_CLEAR: begin
        wr_stb_nx  = 1'b1;
        wr_pos_nx  = clear_pos;
        wr_char_nx = CLEAR_CHAR;
        if (clear_pos == LAST_CELL) begin
          clear_pos_nx = '0;
          state_nx     = ST_IDLE;
        end else begin
          clear_pos_nx = clear_pos + ADDR_ONE;
        end
      end

      ST_IDLE: begin
        if (bus.in_valid) begin
          case (bus.in_char) inside
            [8'h20:8'h7E]: begin
              wr_stb_nx  = 1'b1;
              wr_pos_nx  = cursor;
              wr_char_nx = bus.in_char;
              // The last cell wraps to the top-left corner; the screen never scrolls.
              if (cursor == LAST_CELL) begin
                cursor_nx = '0;
                col_nx    = '0;
                row_nx    = '0;
              end else if (col == LAST_COL) begin
                cursor_nx = cursor + ADDR_ONE;
                col_nx    = '0;
                row_nx    = row + ROW_ONE;
              end else begin
                cursor_nx = cursor + ADDR_ONE;
                col_nx    = col + COL_ONE;
              end
            end

            CH_CR: begin
              cursor_nx = cursor - ADDR_W'(col);
              col_nx    = '0;
            end

            CH_LF: begin
              col_nx = '0;
              if (row == LAST_ROW) begin
                row_nx    = '0;
                cursor_nx = '0;
              end else begin
                row_nx    = row + ROW_ONE;
                cursor_nx = cursor + (COLS_A - ADDR_W'(col));
              end
            end

            CH_BS: begin
              if (col != '0) begin
                col_nx     = col - COL_ONE;
                cursor_nx  = cursor - ADDR_ONE;
                wr_stb_nx  = 1'b1;
                wr_pos_nx  = cursor - ADDR_ONE;
                wr_char_nx = CLEAR_CHAR;
              end
            end

            CH_FF: begin
              cursor_nx    = '0;
              col_nx       = '0;
              row_nx       = '0;
              clear_pos_nx = '0;
              state_nx     = ST_CLEAR;
            end

            default: ;
          endcase
        end
      end

      default: state_nx = ST_CLEAR;
    endcase
  end

  // Ready and busy are decoded straight from the state register, so they are glitch-free.
  assign bus.in_ready            = (state == ST_IDLE);
  assign bus.busy                = (state == ST_CLEAR);
  assign bus.write_strobe        = wr_stb;
  assign bus.write_character_pos = wr_pos;
  assign bus.write_character     = wr_char;
  assign bus.cursor_pos          = cursor;

endmodule
